pmp_check_arbiter: RTL and testbench

Shares the single PMP/PMA address-permission checker of the E31 core between the instruction-fetch and load/store requesters. It arbitrates round-robin and drives a registered request into the checker. It then captures the checker's fault result and returns it to the granted requester over a valid/ready handshake. It also blocks checks while a PMP configuration write is in flight and keeps a saturating count of faults.

---
 rtl/pmp_check_arbiter.sv | 145 ++++++++++++++
 tb/tb_pmp_check_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmp_check_arbiter.sv
// Round-robin arbiter sharing one PMP/PMA checker between fetch and load/store.
// Latency: accept N -> chk_* valid N+1 -> rsp_valid N+2, plus one cycle per cfg_busy cycle in CHECK.
// Backpressure: one transaction in flight; requests wait (req_ready low) until the response handshake completes.
module pmp_check_arbiter (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_req_addr,
    input  logic [1:0]  if_req_cmd,
    input  logic [1:0]  if_req_size,
    input  logic [1:0]  if_req_priv,
    input  logic        ls_req_valid,
    output logic        ls_req_ready,
    input  logic [31:0] ls_req_addr,
    input  logic [1:0]  ls_req_cmd,
    input  logic [1:0]  ls_req_size,
    input  logic [1:0]  ls_req_priv,
    output logic [31:0] chk_addr,
    output logic [1:0]  chk_cmd,
    output logic [1:0]  chk_priv,
    input  logic        chk_fault,
    input  logic        cfg_busy,
    output logic        if_rsp_valid,
    input  logic        if_rsp_ready,
    output logic        ls_rsp_valid,
    input  logic        ls_rsp_ready,
    output logic        rsp_fault,
    output logic [7:0]  fault_count,
    input  logic        fault_count_clr
);

    typedef struct packed {
        logic [31:0] addr;
        logic [1:0]  cmd;
        logic [1:0]  size;
        logic [1:0]  priv;
    } req_t;

    typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;

    state_t state, state_nxt;
    req_t   if_req, ls_req, sel_req;
    logic   gnt_ls, gnt_any, accept;
    logic   sel_misalign, misalign;
    logic   owner, last_grant;       // 0 = fetch, 1 = load/store
    logic   sample, handshake;

    assign if_req = '{addr: if_req_addr, cmd: if_req_cmd, size: if_req_size, priv: if_req_priv};
    assign ls_req = '{addr: ls_req_addr, cmd: ls_req_cmd, size: ls_req_size, priv: ls_req_priv};

    // Arbitration: a lone requester wins; on a tie the port not granted last time wins.
    always_comb begin
        gnt_any = if_req_valid | ls_req_valid;
        gnt_ls  = ls_req_valid & (~if_req_valid | ~last_grant);
        sel_req = gnt_ls ? ls_req : if_req;
        accept  = reset_n & (state == IDLE) & ~cfg_busy & gnt_any;
        if_req_ready = accept & ~gnt_ls;
        ls_req_ready = accept & gnt_ls;
    end

    // Alignment and reserved-encoding faults are decided locally, not by the checker.
    always_comb begin
        sel_misalign = 1'b0;
        if (sel_req.cmd == 2'd3 || sel_req.size == 2'd3)
            sel_misalign = 1'b1;
        else if (sel_req.size == 2'd1)
            sel_misalign = sel_req.addr[0];
        else if (sel_req.size == 2'd2)
            sel_misalign = (sel_req.addr[1:0] != 2'b00);
    end

    // Next-state and response handshake decode.
    always_comb begin
        state_nxt    = state;
        sample       = 1'b0;
        handshake    = 1'b0;
        if_rsp_valid = 1'b0;
        ls_rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (accept)
                    state_nxt = CHECK;
            end
            CHECK: begin
                // Checker output is untrustworthy while the PMP CSRs are being written.
                if (!cfg_busy) begin
                    sample    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if_rsp_valid = ~owner;
                ls_rsp_valid = owner;
                handshake    = owner ? ls_rsp_ready : if_rsp_ready;
                if (handshake)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Checker request capture on accept and verdict capture when sampled.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            chk_addr   <= 32'd0;
            chk_cmd    <= 2'd0;
            chk_priv   <= 2'd0;
            misalign   <= 1'b0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            rsp_fault  <= 1'b0;
        end else begin
            if (accept) begin
                chk_addr   <= sel_req.addr;
                chk_cmd    <= sel_req.cmd;
                chk_priv   <= sel_req.priv;
                misalign   <= sel_misalign;
                owner      <= gnt_ls;
                last_grant <= gnt_ls;
            end
            if (sample)
                rsp_fault <= chk_fault | misalign;
        end
    end

    // Saturating count of faulting responses actually delivered; clear wins.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            fault_count <= 8'd0;
        else if (fault_count_clr)
            fault_count <= 8'd0;
        else if (handshake && rsp_fault && fault_count != 8'hFF)
            fault_count <= fault_count + 8'd1;
    end

endmodule

// File: tb/tb_pmp_check_arbiter.sv
// Bench for pmp_check_arbiter: directed vectors, transaction-level model, per-cycle compare.
// Latency: inputs change at negedge, outputs compared 3-4 time units later, model advances at posedge.
// Backpressure: rsp_ready patterns driven directly by the directed sequences.
module tb_pmp_check_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        if_req_valid, ls_req_valid;
    logic        if_req_ready, ls_req_ready;
    logic [31:0] if_req_addr, ls_req_addr;
    logic [1:0]  if_req_cmd, ls_req_cmd, if_req_size, ls_req_size, if_req_priv, ls_req_priv;
    logic [31:0] chk_addr;
    logic [1:0]  chk_cmd, chk_priv;
    logic        chk_fault, cfg_busy;
    logic        if_rsp_valid, ls_rsp_valid, if_rsp_ready, ls_rsp_ready;
    logic        rsp_fault;
    logic [7:0]  fault_count;
    logic        fault_count_clr;

    int pass_cnt = 0;
    int total_cnt = 0;

    pmp_check_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_req_cmd(if_req_cmd), .if_req_size(if_req_size), .if_req_priv(if_req_priv),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_addr(ls_req_addr),
        .ls_req_cmd(ls_req_cmd), .ls_req_size(ls_req_size), .ls_req_priv(ls_req_priv),
        .chk_addr(chk_addr), .chk_cmd(chk_cmd), .chk_priv(chk_priv),
        .chk_fault(chk_fault), .cfg_busy(cfg_busy),
        .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_ready(ls_rsp_ready),
        .rsp_fault(rsp_fault), .fault_count(fault_count), .fault_count_clr(fault_count_clr)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp)
            pass_cnt++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    endtask

    // ---------------- transaction-level model ----------------
    bit          m_inflight;   // a request has been accepted and not yet answered
    bit          m_answered;   // its verdict is known and offered to the owner
    int          m_owner;      // 0 fetch, 1 load/store
    int          m_last;       // port granted most recently
    int          m_count;
    bit          m_fault;
    bit          m_bad;
    logic [31:0] m_addr;
    logic [1:0]  m_cmd, m_priv;

    function automatic bit bad_access(input logic [31:0] addr, input logic [1:0] cmd, input logic [1:0] size);
        int bytes;
        if (cmd == 2'd3 || size == 2'd3) return 1'b1;
        bytes = 1 << size;
        return (addr % bytes) != 0;
    endfunction

    task automatic model_reset();
        m_inflight = 0; m_answered = 0; m_owner = 0; m_last = 1; m_count = 0;
        m_fault = 0; m_bad = 0; m_addr = 32'd0; m_cmd = 2'd0; m_priv = 2'd0;
    endtask

    function automatic bit wants_if();
        return if_req_valid && (!ls_req_valid || m_last == 1);
    endfunction

    function automatic bit wants_ls();
        return ls_req_valid && (!if_req_valid || m_last == 0);
    endfunction

    task automatic model_compare();
        bit open;
        open = reset_n && !m_inflight && !cfg_busy;
        check("if_req_ready", if_req_ready, open && wants_if());
        check("ls_req_ready", ls_req_ready, open && wants_ls());
        check("chk_addr", chk_addr, m_addr);
        check("chk_cmd", chk_cmd, m_cmd);
        check("chk_priv", chk_priv, m_priv);
        check("fault_count", fault_count, m_count);
        check("if_rsp_valid", if_rsp_valid, m_answered && m_owner == 0);
        check("ls_rsp_valid", ls_rsp_valid, m_answered && m_owner == 1);
        if (m_answered)
            check("rsp_fault", rsp_fault, m_fault);
    endtask

    task automatic model_step();
        bit taken;
        taken = (m_owner == 1) ? ls_rsp_ready : if_rsp_ready;
        if (fault_count_clr)
            m_count = 0;
        else if (m_answered && taken && m_fault && m_count < 255)
            m_count = m_count + 1;
        if (m_answered) begin
            if (taken) begin
                m_answered = 0;
                m_inflight = 0;
            end
        end else if (m_inflight) begin
            if (!cfg_busy) begin
                m_fault = chk_fault || m_bad;
                m_answered = 1;
            end
        end else if (!cfg_busy && (if_req_valid || ls_req_valid)) begin
            if (wants_if()) begin
                m_owner = 0; m_addr = if_req_addr; m_cmd = if_req_cmd; m_priv = if_req_priv;
                m_bad = bad_access(if_req_addr, if_req_cmd, if_req_size);
            end else begin
                m_owner = 1; m_addr = ls_req_addr; m_cmd = ls_req_cmd; m_priv = ls_req_priv;
                m_bad = bad_access(ls_req_addr, ls_req_cmd, ls_req_size);
            end
            m_last = m_owner;
            m_inflight = 1;
        end
    endtask

    // Single compare process: compare before the edge, advance the model on it.
    initial begin
        model_reset();
        forever begin
            @(negedge clock);
            #3;
            if (!reset_n) model_reset();
            model_compare();
            @(posedge clock);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic nxt();
        @(negedge clock);
    endtask

    task automatic mid();
        #4;
    endtask

    task automatic set_if(input logic v, input logic [31:0] a, input logic [1:0] c, input logic [1:0] s, input logic [1:0] p);
        if_req_valid = v; if_req_addr = a; if_req_cmd = c; if_req_size = s; if_req_priv = p;
    endtask

    task automatic set_ls(input logic v, input logic [31:0] a, input logic [1:0] c, input logic [1:0] s, input logic [1:0] p);
        ls_req_valid = v; ls_req_addr = a; ls_req_cmd = c; ls_req_size = s; ls_req_priv = p;
    endtask

    task automatic do_reset();
        nxt(); reset_n = 1'b0;
        nxt(); reset_n = 1'b1;
    endtask

    int exp_acc [12] = '{1, 0, 0, 2, 0, 0, 1, 0, 0, 2, 0, 0};
    int acc;

    initial begin
        reset_n = 1'b0;
        set_if(0, 32'd0, 2'd0, 2'd0, 2'd0);
        set_ls(0, 32'd0, 2'd0, 2'd0, 2'd0);
        chk_fault = 0; cfg_busy = 0; if_rsp_ready = 0; ls_rsp_ready = 0; fault_count_clr = 0;

        // Reset values
        nxt(); mid();
        check("reset_chk_addr", chk_addr, 32'd0);
        check("reset_fault_count", fault_count, 32'd0);
        check("reset_if_rsp_valid", if_rsp_valid, 1'b0);
        nxt(); reset_n = 1'b1;

        // Single fetch, exec, aligned word, M-mode
        nxt(); set_if(1, 32'h8000_0000, 2'd2, 2'd2, 2'd3); mid();
        check("t1_accept", if_req_ready, 1'b1);
        nxt(); set_if(0, 32'd0, 2'd0, 2'd0, 2'd0); mid();
        check("t1_chk_addr", chk_addr, 32'h8000_0000);
        check("t1_chk_cmd", chk_cmd, 2'd2);
        check("t1_chk_priv", chk_priv, 2'd3);
        nxt(); if_rsp_ready = 1; mid();
        check("t1_rsp_valid", if_rsp_valid, 1'b1);
        check("t1_rsp_fault", rsp_fault, 1'b0);
        nxt(); if_rsp_ready = 0; mid();
        check("t1_count", fault_count, 32'd0);
        check("t1_idle", if_rsp_valid, 1'b0);

        // Round-robin from reset with both ports always valid
        do_reset();
        nxt();
        set_if(1, 32'h0000_1000, 2'd0, 2'd2, 2'd0);
        set_ls(1, 32'h0000_2000, 2'd1, 2'd2, 2'd0);
        if_rsp_ready = 1; ls_rsp_ready = 1;
        for (int c = 0; c < 12; c++) begin
            mid();
            acc = if_req_ready ? 1 : (ls_req_ready ? 2 : 0);
            check($sformatf("rr_accept_c%0d", c), acc, exp_acc[c]);
            nxt();
        end
        set_if(0, 32'd0, 2'd0, 2'd0, 2'd0);
        set_ls(0, 32'd0, 2'd0, 2'd0, 2'd0);

        // Misaligned load/store write faults without checker help
        nxt(); set_ls(1, 32'h2000_0002, 2'd1, 2'd2, 2'd0); mid();
        check("t3_accept", ls_req_ready, 1'b1);
        nxt(); set_ls(0, 32'd0, 2'd0, 2'd0, 2'd0);
        nxt(); mid();
        check("t3_rsp_valid", ls_rsp_valid, 1'b1);
        check("t3_rsp_fault", rsp_fault, 1'b1);
        nxt(); mid();
        check("t3_count", fault_count, 32'd1);

        // cfg_busy for three cycles after accept; verdict taken from first free cycle
        nxt(); set_if(1, 32'h0000_0100, 2'd0, 2'd2, 2'd1); chk_fault = 0; mid();
        check("t4_accept", if_req_ready, 1'b1);
        nxt(); set_if(0, 32'd0, 2'd0, 2'd0, 2'd0); cfg_busy = 1; chk_fault = 0;
        nxt(); chk_fault = 1;
        nxt(); chk_fault = 0;
        nxt(); cfg_busy = 0; chk_fault = 1; mid();
        check("t4_no_rsp_c4", if_rsp_valid, 1'b0);
        nxt(); chk_fault = 0; mid();
        check("t4_rsp_valid_c5", if_rsp_valid, 1'b1);
        check("t4_rsp_fault", rsp_fault, 1'b1);
        nxt(); mid();
        check("t4_count", fault_count, 32'd2);

        // Load/store response stalled four cycles while fetch waits
        nxt(); set_ls(1, 32'h0000_0003, 2'd0, 2'd0, 2'd0); chk_fault = 1; ls_rsp_ready = 0; mid();
        check("t5_accept", ls_req_ready, 1'b1);
        nxt(); set_ls(0, 32'd0, 2'd0, 2'd0, 2'd0); set_if(1, 32'h0000_0400, 2'd0, 2'd2, 2'd3);
        for (int c = 2; c < 6; c++) begin
            nxt(); mid();
            check($sformatf("t5_hold_valid_c%0d", c), ls_rsp_valid, 1'b1);
            check($sformatf("t5_hold_fault_c%0d", c), rsp_fault, 1'b1);
            check($sformatf("t5_if_blocked_c%0d", c), if_req_ready, 1'b0);
        end
        nxt(); ls_rsp_ready = 1;
        nxt(); ls_rsp_ready = 0; chk_fault = 0; mid();
        check("t5_if_accept", if_req_ready, 1'b1);
        check("t5_count", fault_count, 32'd3);
        nxt(); set_if(0, 32'd0, 2'd0, 2'd0, 2'd0);
        nxt(); nxt(); nxt();

        // Saturation, then clear racing a faulting handshake
        do_reset();
        nxt(); set_if(1, 32'h0, 2'd3, 2'd0, 2'd0); chk_fault = 0; if_rsp_ready = 1;
        repeat (261 * 3) nxt();
        set_if(0, 32'd0, 2'd0, 2'd0, 2'd0); mid();
        check("t6_saturated", fault_count, 32'd255);
        nxt(); set_if(1, 32'h10, 2'd3, 2'd0, 2'd0);
        nxt(); set_if(0, 32'd0, 2'd0, 2'd0, 2'd0);
        nxt(); fault_count_clr = 1; mid();
        check("t6_rsp_valid", if_rsp_valid, 1'b1);
        nxt(); fault_count_clr = 0; mid();
        check("t6_clr_wins", fault_count, 32'd0);

        // Asynchronous reset while a check is pending
        nxt(); set_if(1, 32'h20, 2'd3, 2'd0, 2'd0);
        nxt(); set_if(0, 32'd0, 2'd0, 2'd0, 2'd0);
        nxt(); nxt(); mid();
        check("t7_pre_count", fault_count, 32'd1);
        nxt(); set_if(1, 32'h0000_5550, 2'd1, 2'd2, 2'd3);
        nxt(); reset_n = 1'b0; #1;
        check("t7_rst_chk_addr", chk_addr, 32'd0);
        check("t7_rst_chk_cmd", chk_cmd, 2'd0);
        check("t7_rst_chk_priv", chk_priv, 2'd0);
        check("t7_rst_count", fault_count, 32'd0);
        check("t7_rst_if_ready", if_req_ready, 1'b0);
        nxt(); reset_n = 1'b1; set_if(0, 32'd0, 2'd0, 2'd0, 2'd0);
        nxt(); nxt(); mid();
        check("t7_no_rsp", if_rsp_valid, 1'b0);
        nxt();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
